// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared types and constants for the USB receive bit timer.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_pkg;

  // Receive bit timer FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rx_timer_state_t;

  // Number of consecutive 1s after which the transmitter inserts a stuffed 0
  localparam int STUFF_LIMIT = 6;

  // Default bit period in system clocks and the derived mid-bit sample phase
  localparam int DEFAULT_CLKS_PER_BIT = 8;
  localparam int DEFAULT_SAMPLE_PT    = DEFAULT_CLKS_PER_BIT / 2;

endpackage
`default_nettype wire

// File: rtl/rx_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : rx_phase_counter
// Description : Bit-phase counter. Counts 1..rollover_val and wraps to 1.
//               clear forces 0 (idle), load forces 1 (resync), enable
//               advances the count. Priority: clear > load > enable.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_phase_counter #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                load,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] rollover_val,
  output logic [CNT_BITS-1:0] count
);

  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] r_count;

  // Phase register: clear to 0, load to 1, otherwise count and wrap to 1
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= ONE;
    end else if (enable) begin
      r_count <= (r_count == rollover_val) ? ONE : r_count + ONE;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer
// Description : USB receive bit timing. Recovers the mid-bit sample point
//               from line edges, strobes shift_enable once per data bit,
//               drops stuffed bits (stuff_skip), counts bits per byte and
//               flags byte boundaries.
//               Build option RX_STUFF_CHECK_EN: when defined, stuff_err
//               pulses for a stuffed bit received as 1; otherwise stuff_err
//               is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_BITS     = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       stuff_skip,
  output logic       byte_received,
  output logic [2:0] bit_cnt,
  output logic       stuff_err
);

  localparam logic [CNT_BITS-1:0] ROLLOVER_VAL = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] SAMPLE_PT    = CNT_BITS'(CLKS_PER_BIT / 2);
  localparam logic [2:0]          STUFF_RUN    = 3'(STUFF_LIMIT);

  rx_timer_state_t     r_state;
  rx_timer_state_t     w_next_state;
  logic [CNT_BITS-1:0] w_phase;
  logic                w_phase_clear;
  logic                w_phase_load;
  logic                w_phase_enable;
  logic                w_sample;
  logic                w_shift;
  logic                w_skip;
  logic [2:0]          r_ones_run;
  logic [2:0]          r_bit_cnt;
  logic                r_byte_received;

  rx_phase_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_phase (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_phase_clear),
    .load         (w_phase_load),
    .enable       (w_phase_enable),
    .rollover_val (ROLLOVER_VAL),
    .count        (w_phase)
  );

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, phase counter control, and sample decode from registered state
  always_comb begin
    w_next_state   = r_state;
    w_phase_clear  = 1'b0;
    w_phase_load   = 1'b0;
    w_phase_enable = 1'b0;
    case (r_state)
      IDLE: begin
        if (rcving && d_edge) begin
          w_next_state = RUN;
          w_phase_load = 1'b1;
        end else begin
          w_phase_clear = 1'b1;
        end
      end
      RUN: begin
        if (!rcving) begin
          w_next_state  = IDLE;
          w_phase_clear = 1'b1;
        end else begin
          w_phase_enable = 1'b1;
          w_phase_load   = d_edge;
        end
      end
      default: begin
        w_next_state  = IDLE;
        w_phase_clear = 1'b1;
      end
    endcase
    // Strobes depend only on state, phase and ones_run, never on inputs
    w_sample = (r_state == RUN) && (w_phase == SAMPLE_PT);
    w_shift  = w_sample && (r_ones_run != STUFF_RUN);
    w_skip   = w_sample && (r_ones_run == STUFF_RUN);
  end

  // Ones run length, bit count and byte boundary; frozen when rcving drops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ones_run      <= '0;
      r_bit_cnt       <= '0;
      r_byte_received <= 1'b0;
    end else begin
      r_byte_received <= w_shift && rcving && (r_bit_cnt == 3'd7);
      if ((r_state == RUN) && !rcving) begin
        r_ones_run <= '0;
        r_bit_cnt  <= '0;
      end else if (w_shift && rcving) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_ones_run <= d_orig ? r_ones_run + 3'd1 : 3'd0;
      end else if (w_skip && rcving) begin
        r_ones_run <= '0;
      end
    end
  end

`ifdef RX_STUFF_CHECK_EN
  logic r_stuff_err;

  // A stuffed bit must be 0; a 1 here is a bit-stuff violation
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stuff_err <= 1'b0;
    end else begin
      r_stuff_err <= w_skip && rcving && d_orig;
    end
  end

  assign stuff_err = r_stuff_err;
`else
  assign stuff_err = 1'b0;
`endif

  assign shift_enable  = w_shift;
  assign stuff_skip    = w_skip;
  assign byte_received = r_byte_received;
  assign bit_cnt       = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_bit_timer
// Description : Self-checking bench for rx_bit_timer. Stimulus tasks push
//               the expected output events (cycle + output values) into a
//               queue; a monitor pops and compares whenever the DUT shows
//               any strobe. Honours RX_STUFF_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_bit_timer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rcving = 1'b0;
  logic       d_edge = 1'b0;
  logic       d_orig = 1'b0;
  logic       shift_enable;
  logic       stuff_skip;
  logic       byte_received;
  logic [2:0] bit_cnt;
  logic       stuff_err;

`ifdef RX_STUFF_CHECK_EN
  localparam bit STUFF_CHK = 1'b1;
`else
  localparam bit STUFF_CHK = 1'b0;
`endif

  // Expected event: cycle and {shift_enable, stuff_skip, byte_received, stuff_err, bit_cnt}
  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [6:0] mon_act;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_bc = 0;
  int         exp_ones = 0;

  rx_bit_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rcving        (rcving),
    .d_edge        (d_edge),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .stuff_skip    (stuff_skip),
    .byte_received (byte_received),
    .bit_cnt       (bit_cnt),
    .stuff_err     (stuff_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe cycle must match the next queued expectation
  always @(negedge clk) begin
    if (n_rst && (shift_enable || stuff_skip || byte_received || stuff_err)) begin
      mon_act = {shift_enable, stuff_skip, byte_received, stuff_err, bit_cnt};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cycle %0d: got {se,ss,br,err,cnt}=%b, required no event", cyc, mon_act);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.cyc != cyc) || (mon_e.val != mon_act)) begin
          n_fail++;
          $display("FAIL event: got cycle %0d {se,ss,br,err,cnt}=%b, required cycle %0d %b",
                   cyc, mon_act, mon_e.cyc, mon_e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic se, input logic ss, input logic br,
                      input logic er, input logic [2:0] bc);
    exp_t e;
    e.cyc = c;
    e.val = {se, ss, br, er, bc};
    exp_q.push_back(e);
  endtask

  // One bit: edge at its first cycle, sample expected 4 cycles later
  task automatic send_bit(input logic d, input int len);
    int c0;
    c0     = cyc;
    rcving = 1'b1;
    d_orig = d;
    d_edge = 1'b1;
    if (exp_ones == 6) begin
      push(c0 + 4, 1'b0, 1'b1, 1'b0, 1'b0, 3'(exp_bc));
      if (STUFF_CHK && d) push(c0 + 5, 1'b0, 1'b0, 1'b0, 1'b1, 3'(exp_bc));
      exp_ones = 0;
    end else begin
      push(c0 + 4, 1'b1, 1'b0, 1'b0, 1'b0, 3'(exp_bc));
      exp_ones = d ? exp_ones + 1 : 0;
      exp_bc   = (exp_bc + 1) % 8;
      if (exp_bc == 0) push(c0 + 5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    end
    tick();
    d_edge = 1'b0;
    repeat (len - 1) tick();
  endtask

  task automatic end_packet(input string name);
    rcving = 1'b0;
    d_edge = 1'b0;
    tick();
    tick();
    exp_bc   = 0;
    exp_ones = 0;
    check({name, "_bit_cnt"}, 8'(bit_cnt), 8'd0);
    check({name, "_shift"}, 8'(shift_enable), 8'd0);
  endtask

  // rcving falls in the very cycle of a sample
  task automatic drop_at_sample();
    int c0;
    c0     = cyc;
    rcving = 1'b1;
    d_orig = 1'b0;
    d_edge = 1'b1;
    push(c0 + 4, 1'b1, 1'b0, 1'b0, 1'b0, 3'(exp_bc));
    tick();
    d_edge = 1'b0;
    repeat (3) tick();
    rcving = 1'b0;
    tick();
    tick();
    exp_bc   = 0;
    exp_ones = 0;
    check("drop_at_sample_bit_cnt", 8'(bit_cnt), 8'd0);
    check("drop_at_sample_byte_received", 8'(byte_received), 8'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("reset_shift", 8'(shift_enable), 8'd0);
    check("reset_skip", 8'(stuff_skip), 8'd0);
    check("reset_byte", 8'(byte_received), 8'd0);
    check("reset_bit_cnt", 8'(bit_cnt), 8'd0);
    check("reset_stuff_err", 8'(stuff_err), 8'd0);
    n_rst = 1'b1;
    tick();

    // Receiving but no edge yet: stays idle, no strobes
    rcving = 1'b1;
    repeat (5) tick();
    check("idle_no_edge_bit_cnt", 8'(bit_cnt), 8'd0);

    // Steady zeros: 16 bits, two bytes
    for (int i = 0; i < 16; i++) send_bit(1'b0, 8);
    end_packet("steady0");

    // Six ones then a stuffed zero, then one more data bit
    for (int i = 0; i < 6; i++) send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    end_packet("stuff_ok");

    // Six ones then a stuffed one (violation), then a data one
    for (int i = 0; i < 6; i++) send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    end_packet("stuff_violation");

    // Resync: early edge at phase 6, then edge coincident with a sample
    send_bit(1'b0, 8);
    send_bit(1'b0, 6);
    send_bit(1'b0, 4);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    end_packet("resync");

    // Early end after five data bits: no byte_received
    for (int i = 0; i < 5; i++) send_bit(1'b0, 8);
    end_packet("early_end");

    // rcving drops on the 8th sample: shift shows, byte_received suppressed
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8);
    drop_at_sample();

    // Asynchronous reset at phase 3 of a bit
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    rcving = 1'b1;
    d_orig = 1'b0;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_bit_cnt", 8'(bit_cnt), 8'd0);
    check("async_rst_shift", 8'(shift_enable), 8'd0);
    check("async_rst_skip", 8'(stuff_skip), 8'd0);
    check("async_rst_byte", 8'(byte_received), 8'd0);
    tick();
    tick();
    n_rst    = 1'b1;
    exp_bc   = 0;
    exp_ones = 0;
    // Back in IDLE: no strobes without an entry edge
    repeat (10) tick();
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    end_packet("after_reset");

    repeat (4) tick();
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_bit_timer.md
# rx_bit_timer

Receive-side bit timing block for the USB receive path of the bridge. It recovers the bit sampling point from line transitions, generates one mid-bit shift strobe per bit, removes stuffed bits, and marks byte boundaries for the receive shift register and receive controller. It is the receive counterpart of the transmit bit-rate counter and sits between the line edge detector / NRZI decoder and the receive shift register.

## Interface
- CLKS_PER_BIT, 8, system clocks per USB bit period (must be ≥ 4)
- CNT_BITS, 4, width of the phase counter; must hold CLKS_PER_BIT
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- rcving  in  1  high while the receive controller has a packet in progress
- d_edge  in  1  single-cycle pulse on any line transition
- d_orig  in  1  NRZI-decoded bit value, valid at the sample point
- shift_enable  out  1  one-cycle strobe: shift d_orig into the receive shift register
- stuff_skip  out  1  one-cycle strobe: current sample is a stuffed bit and is discarded
- byte_received  out  1  one-cycle pulse after the 8th data bit of a byte
- bit_cnt  out  3  data bits accepted in the current byte (0–7)
- stuff_err  out  1  one-cycle pulse: stuffed bit was 1 (bit-stuff violation)

## Operation
- FSM states: IDLE, RUN. Reset state is IDLE.
- IDLE → RUN when rcving=1 and d_edge=1. The phase register loads 1.
- RUN → IDLE on any cycle with rcving=0. phase, ones_run, and bit_cnt all clear. No byte_received is issued for a partial byte.
- Phase counter in RUN:
  - d_edge=1: next phase = 1 (resync).
  - phase == CLKS_PER_BIT: next phase = 1 (wrap).
  - Otherwise: phase + 1.
- SAMPLE_PT = CLKS_PER_BIT/2. A sample occurs in RUN when phase == SAMPLE_PT.
- ones_run (0–6) counts consecutive accepted 1 bits.
- At a sample with ones_run < 6 (data bit):
  - shift_enable = 1.
  - ones_run ← ones_run+1 if d_orig=1, else 0.
  - bit_cnt ← bit_cnt+1, wrapping 7→0.
- At a sample with ones_run == 6 (stuff bit):
  - stuff_skip = 1, shift_enable = 0.
  - bit_cnt unchanged, ones_run ← 0.
  - If d_orig=1, stuff_err pulses.
- byte_received is registered. It pulses the cycle after a shift_enable that takes bit_cnt 7→0, provided rcving is still 1 in that shift cycle.

## Timing
- All outputs are 0 out of reset and in IDLE.
- shift_enable and stuff_skip are decoded only from registered state (phase, ones_run, FSM), with no combinational input path. They are high for exactly one cycle per bit period.
- Latency: entry edge at cycle 0 → phase=1 at cycle 1 → first sample at cycle SAMPLE_PT (cycle 4 for the default).
- d_edge coincident with a sample: the sample still occurs, and phase restarts at 1 on the next cycle.
- rcving=0 coincident with a sample: that sample's shift_enable still asserts, since it is state-decoded. The bit_cnt, ones_run, and byte_received updates are suppressed.
- stuff_err and byte_received are registered, each asserting one cycle after its causing sample.
- Reset mid-packet: asynchronous return to IDLE with all outputs 0.

## Configuration
- RX_STUFF_CHECK_EN defined: stuff_err is driven as described above.
- RX_STUFF_CHECK_EN undefined: the stuff_err port remains but is tied to 0, and its register is not built. Stuffed-bit removal (stuff_skip, ones_run) is unaffected.

## Structure
- Package usb_rx_pkg holds:
  - the rx_timer_state_t enum (IDLE, RUN),
  - STUFF_LIMIT = 6,
  - the default CLKS_PER_BIT and the derived SAMPLE_PT.
- Sub-module rx_phase_counter: a CNT_BITS-wide counter with clear, synchronous load-to-1, enable, and rollover_val input. It counts 1..rollover_val and wraps to 1. rx_bit_timer instantiates it once for phase. ones_run and bit_cnt are local registers.

## Test plan
- Steady 0 data: rcving=1, d_edge every 8 clocks for 16 bits → shift_enable at phase 4 of every bit, two byte_received pulses, stuff_skip never asserted.
- Six 1s then 0 stuff bit: d_orig=1 for 6 samples, then 0 at the 7th → 7th sample gives stuff_skip=1, shift_enable=0, bit_cnt holds at 6, stuff_err=0.
- Stuff violation: 7th consecutive sample with d_orig=1 → stuff_err pulses one cycle later when RX_STUFF_CHECK_EN is defined; stuff_err stays 0 when it is not.
- Resync: d_edge arrives at phase 6 instead of 8 → phase=1 the next cycle, and the next shift_enable occurs 4 cycles after the edge.
- Early end: rcving drops after 5 data bits → IDLE the next cycle, bit_cnt=0, no byte_received, outputs quiet.
- Async reset asserted in RUN at phase 3 → all outputs 0 immediately; FSM in IDLE after reset release.
